stage_if: RTL and testbench

Instruction-fetch stage plus the IF/ID pipeline register. It sits directly upstream of stage_ID and feeds it PCAddResult and Instruction.
- Owns the PC register and the PC+4 adder.
- Drives the instruction-memory read address.
- Applies redirects (branch taken, JR) and stall/flush from the hazard logic.
- Presents a registered instruction, its PC+4 and a valid bit to decode.

---
 rtl/pipeline_defs.sv | 29 ++
 rtl/pc_register.sv | 45 ++++
 rtl/stage_if.sv | 86 ++++++++
 tb/tb_stage_if.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_defs.sv
// Shared pipeline definitions used by the IF and ID stages.
package pipeline_defs;

  // sll $0,$0,0: the bubble word placed into IF/ID when it is emptied
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field bit ranges, shared with decode
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;

  // IF/ID occupancy: EMPTY holds a bubble, VALID holds a real fetch
  typedef enum logic {
    IFID_EMPTY = 1'b0,
    IFID_VALID = 1'b1
  } ifid_state_t;

  // Word-aligns a redirect target; low address bits are silently dropped
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter flop with redirect-aware next-PC selection.
module pc_register
  import pipeline_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic [31:0] pc_plus4,
  output logic [31:0] pc
);

  logic        redirect;
  logic        enable;
  logic [31:0] next_pc;

  assign redirect = branch_taken | jr;
  // A redirect must land even while the pipeline is stalled
  assign enable   = ~stall | redirect;

  // Next-PC mux: the branch is older than the JR in ID, so it wins
  always_comb begin
    next_pc = pc_plus4;
    if (branch_taken) begin
      next_pc = align_word(branch_target);
    end else if (jr) begin
      next_pc = align_word(jr_target);
    end
  end

  // PC register with asynchronous reset and load enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (enable) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/stage_if.sv
// Instruction fetch stage and IF/ID pipeline register.
//
// Handshake: there is no ready/valid backpressure. Stall_in freezes PC and
// IF/ID for the cycle; Valid_out_IF marks whether IF/ID carries a real
// instruction (1) or a bubble (0). Decode may consume whenever it is high.
module stage_if
  import pipeline_defs::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = pipeline_defs::NOP_INSTR
) (
  input  logic        Clk_in,
  input  logic        Reset_in,
  input  logic        Stall_in,
  input  logic        Flush_in,
  input  logic        BranchTaken_in,
  input  logic [31:0] BranchTarget_in,
  input  logic        JR_in,
  input  logic [31:0] JRTarget_in,
  output logic [31:0] IMemAddr_out,
  input  logic [31:0] IMemData_in,
  output logic [31:0] PCAddResult_out_IF,
  output logic [31:0] Instruction_out_IF,
  output logic        Valid_out_IF,
  output logic [31:0] PC_out,
  output logic [31:0] FetchCount_out
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        squash;
  logic        load_valid;
  ifid_state_t state;

  // Natural 32-bit wrap: 0xFFFFFFFC + 4 gives 0
  assign pc_plus4     = pc + 32'd4;
  assign IMemAddr_out = pc;
  assign PC_out       = pc;

  // A redirect discards the fetch currently in flight, as does a flush
  assign squash     = BranchTaken_in | JR_in | Flush_in;
  assign load_valid = ~squash & ~Stall_in;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk          (Clk_in),
    .rst          (Reset_in),
    .stall        (Stall_in),
    .branch_taken (BranchTaken_in),
    .branch_target(BranchTarget_in),
    .jr           (JR_in),
    .jr_target    (JRTarget_in),
    .pc_plus4     (pc_plus4),
    .pc           (pc)
  );

  // IF/ID register and its EMPTY/VALID state; squash beats stall
  always_ff @(posedge Clk_in or posedge Reset_in) begin
    if (Reset_in) begin
      state              <= IFID_EMPTY;
      Instruction_out_IF <= NOP_INSTR;
      PCAddResult_out_IF <= 32'd0;
    end else if (squash) begin
      state              <= IFID_EMPTY;
      Instruction_out_IF <= NOP_INSTR;
      PCAddResult_out_IF <= 32'd0;
    end else if (!Stall_in) begin
      state              <= IFID_VALID;
      Instruction_out_IF <= IMemData_in;
      PCAddResult_out_IF <= pc_plus4;
    end
  end

  assign Valid_out_IF = (state == IFID_VALID);

  // Count real instructions entering IF/ID, saturating at all-ones
  always_ff @(posedge Clk_in or posedge Reset_in) begin
    if (Reset_in) begin
      FetchCount_out <= 32'd0;
    end else if (load_valid && (FetchCount_out != 32'hFFFF_FFFF)) begin
      FetchCount_out <= FetchCount_out + 32'd1;
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Directed testbench for stage_if: main instance at RESET_PC=0 plus a
// second instance at RESET_PC=0xFFFFFFFC to exercise PC wrap.
module tb_stage_if;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc_add;
  logic [31:0] instr;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] fetch_count;

  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_data;
  logic [31:0] w_pc_add;
  logic [31:0] w_instr;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_fetch_count;

  int vectors;
  int miscompares;

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory model: word at address A is 0x20080000 + A
  assign imem_data   = 32'h2008_0000 + imem_addr;
  assign w_imem_data = 32'h2008_0000 + w_imem_addr;

  stage_if #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .Clk_in            (clk),
    .Reset_in          (rst),
    .Stall_in          (stall),
    .Flush_in          (flush),
    .BranchTaken_in    (branch_taken),
    .BranchTarget_in   (branch_target),
    .JR_in             (jr),
    .JRTarget_in       (jr_target),
    .IMemAddr_out      (imem_addr),
    .IMemData_in       (imem_data),
    .PCAddResult_out_IF(pc_add),
    .Instruction_out_IF(instr),
    .Valid_out_IF      (valid),
    .PC_out            (pc),
    .FetchCount_out    (fetch_count)
  );

  stage_if #(
    .RESET_PC (32'hFFFF_FFFC),
    .NOP_INSTR(32'h0000_0000)
  ) dut_wrap (
    .Clk_in            (clk),
    .Reset_in          (rst),
    .Stall_in          (1'b0),
    .Flush_in          (1'b0),
    .BranchTaken_in    (1'b0),
    .BranchTarget_in   (32'd0),
    .JR_in             (1'b0),
    .JRTarget_in       (32'd0),
    .IMemAddr_out      (w_imem_addr),
    .IMemData_in       (w_imem_data),
    .PCAddResult_out_IF(w_pc_add),
    .Instruction_out_IF(w_instr),
    .Valid_out_IF      (w_valid),
    .PC_out            (w_pc),
    .FetchCount_out    (w_fetch_count)
  );

  // Scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the full IF/ID + PC + count picture of the main instance
  task automatic check_state(input string tag, input logic [31:0] e_pc,
                             input logic [31:0] e_pc_add, input logic [31:0] e_instr,
                             input logic e_valid, input logic [31:0] e_count);
    check({tag, ".pc"},      pc,                e_pc);
    check({tag, ".imem"},    imem_addr,         e_pc);
    check({tag, ".pc_add"},  pc_add,            e_pc_add);
    check({tag, ".instr"},   instr,             e_instr);
    check({tag, ".valid"},   {31'd0, valid},    {31'd0, e_valid});
    check({tag, ".count"},   fetch_count,       e_count);
  endtask

  // Advance one clock; sample 1ns after the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    jr            = 1'b0;
    jr_target     = 32'd0;

    // Reset values (release between edges at t=12)
    #12;
    check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check("wrap_reset.pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_reset.imem", w_imem_addr, 32'hFFFF_FFFC);
    rst = 1'b0;

    // Free-running fetch
    step();
    check_state("run1", 32'h4, 32'h4, 32'h2008_0000, 1'b1, 32'd1);
    check("wrap.pc", w_pc, 32'h0);
    check("wrap.pc_add", w_pc_add, 32'h0);
    check("wrap.instr", w_instr, 32'h2007_FFFC);
    check("wrap.valid", {31'd0, w_valid}, 32'd1);
    step();
    check_state("run2", 32'h8, 32'h8, 32'h2008_0004, 1'b1, 32'd2);

    // Stall two cycles at PC=8
    stall = 1'b1;
    step();
    check_state("stall1", 32'h8, 32'h8, 32'h2008_0004, 1'b1, 32'd2);
    step();
    check_state("stall2", 32'h8, 32'h8, 32'h2008_0004, 1'b1, 32'd2);
    stall = 1'b0;
    step();
    check_state("resume", 32'hC, 32'hC, 32'h2008_0008, 1'b1, 32'd3);

    // Branch with stall in the same cycle; unaligned target
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0043;
    stall         = 1'b1;
    step();
    check_state("branch", 32'h40, 32'h0, 32'h0, 1'b0, 32'd3);
    branch_taken = 1'b0;
    stall        = 1'b0;
    step();
    check_state("after_branch", 32'h44, 32'h44, 32'h2008_0040, 1'b1, 32'd4);

    // Branch beats JR
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    jr            = 1'b1;
    jr_target     = 32'h0000_0200;
    step();
    check_state("br_vs_jr", 32'h100, 32'h0, 32'h0, 1'b0, 32'd4);

    // JR alone, unaligned target
    branch_taken = 1'b0;
    jr_target    = 32'h0000_0203;
    step();
    check_state("jr", 32'h200, 32'h0, 32'h0, 1'b0, 32'd4);
    jr = 1'b0;

    // Flush alone: PC advances, IF/ID squashed
    flush = 1'b1;
    step();
    check_state("flush", 32'h204, 32'h0, 32'h0, 1'b0, 32'd4);
    flush = 1'b0;
    step();
    check_state("after_flush", 32'h208, 32'h208, 32'h2008_0204, 1'b1, 32'd5);

    // Flush with stall: PC holds, IF/ID squashed
    flush = 1'b1;
    stall = 1'b1;
    step();
    check_state("flush_stall", 32'h208, 32'h0, 32'h0, 1'b0, 32'd5);
    flush = 1'b0;
    stall = 1'b0;
    step();
    check_state("after_fs", 32'h20C, 32'h20C, 32'h2008_0208, 1'b1, 32'd6);

    // Asynchronous reset mid-cycle during a redirect
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0080;
    #2;
    rst = 1'b1;
    #1;
    check_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    step();
    check_state("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    branch_taken = 1'b0;
    #2;
    rst = 1'b0;
    step();
    check_state("post_rst", 32'h4, 32'h4, 32'h2008_0000, 1'b1, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
